// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter
// Collects golden-nonce reports from NUM_HASHERS hasher cores into one-entry
// capture slots, drains them round-robin into a first-word-fall-through FIFO
// and presents the FIFO head to the serial transmitter via valid/ready.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   golden_valid  per-hasher single-cycle found pulse
//   golden_nonce  hasher i nonce at [i*NONCE_WIDTH +: NONCE_WIDTH]
//   flush         new work loaded; clears slots and FIFO
//   tx_valid      FIFO head valid
//   tx_nonce      FIFO head nonce
//   tx_ready      transmitter accepts head this cycle
//   fifo_count    occupied FIFO entries
//   overflow      sticky: a nonce was dropped
//   found_count   nonces accepted into FIFO (wraps)
//   led_found     toggles on every FIFO push
module golden_nonce_arbiter #(
  parameter int unsigned NUM_HASHERS = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NONCE_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_HASHERS-1:0]             golden_valid,
  input  logic [NUM_HASHERS*NONCE_WIDTH-1:0] golden_nonce,
  input  logic                               flush,
  output logic                               tx_valid,
  output logic [NONCE_WIDTH-1:0]             tx_nonce,
  input  logic                               tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic                               overflow,
  output logic [7:0]                         found_count,
  output logic                               led_found
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned RrW  = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1;
  localparam logic [PtrW:0]  FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [RrW-1:0] RrLast  = RrW'(NUM_HASHERS - 1);

  logic [NUM_HASHERS-1:0] slot_pend_q, slot_pend_d;
  logic [NONCE_WIDTH-1:0] slot_data_q [NUM_HASHERS];
  logic [NONCE_WIDTH-1:0] slot_data_d [NUM_HASHERS];
  logic [RrW-1:0]         rr_q, rr_d;

  logic [NONCE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          count_q;

  logic                   grant_valid;
  logic [RrW-1:0]         grant_idx;
  logic                   push, pop, drop;

  // Round-robin search starting at rr_q; flush suppresses any grant.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!flush && (count_q != FullCnt)) begin
      for (int k = 0; k < NUM_HASHERS; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_HASHERS) idx = idx - NUM_HASHERS;
        if (!grant_valid && slot_pend_q[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx[RrW-1:0];
        end
      end
    end
  end

  assign push = grant_valid;
  assign pop  = (count_q != '0) && tx_ready && !flush;
  assign rr_d = !grant_valid ? rr_q : (grant_idx == RrLast) ? '0 : grant_idx + 1'b1;

  // A slot granted this cycle is free to recapture a simultaneous pulse.
  always_comb begin
    logic granted;
    granted     = 1'b0;
    slot_pend_d = slot_pend_q;
    slot_data_d = slot_data_q;
    drop        = 1'b0;
    if (flush) begin
      slot_pend_d = '0;
    end else begin
      for (int i = 0; i < NUM_HASHERS; i++) begin
        granted = grant_valid && (grant_idx == RrW'(i));
        if (granted) slot_pend_d[i] = 1'b0;
        if (golden_valid[i]) begin
          if (!slot_pend_q[i] || granted) begin
            slot_pend_d[i] = 1'b1;
            slot_data_d[i] = golden_nonce[i*NONCE_WIDTH +: NONCE_WIDTH];
          end else begin
            drop = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_pend_q <= '0;
      for (int i = 0; i < NUM_HASHERS; i++) slot_data_q[i] <= '0;
      rr_q        <= '0;
      overflow    <= 1'b0;
      found_count <= 8'd0;
      led_found   <= 1'b0;
    end else begin
      slot_pend_q <= slot_pend_d;
      slot_data_q <= slot_data_d;
      rr_q        <= rr_d;
      if (drop) overflow <= 1'b1;
      if (push) begin
        found_count <= found_count + 8'd1;
        led_found   <= ~led_found;
      end
    end
  end

  // Flush aligns the write pointer to the read pointer so the head value holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= slot_data_q[grant_idx];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign tx_valid   = (count_q != '0);
  assign tx_nonce   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
module tb_golden_nonce_arbiter;
  localparam int N = 3;
  localparam int D = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   golden_valid;
  logic [N*W-1:0] golden_nonce;
  logic           flush;
  logic           tx_ready;
  logic           tx_valid;
  logic [W-1:0]   tx_nonce;
  logic [$clog2(D):0] fifo_count;
  logic           overflow;
  logic [7:0]     found_count;
  logic           led_found;

  golden_nonce_arbiter #(
    .NUM_HASHERS(N),
    .FIFO_DEPTH (D),
    .NONCE_WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .golden_valid(golden_valid),
    .golden_nonce(golden_nonce),
    .flush       (flush),
    .tx_valid    (tx_valid),
    .tx_nonce    (tx_nonce),
    .tx_ready    (tx_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .found_count (found_count),
    .led_found   (led_found)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q [$];
  int           exp_found = 0;

  typedef struct {
    logic         pv;
    int           idx;
    logic [W-1:0] nonce;
    logic         ready;
    logic         exp_valid;
    int           exp_count;
    int           exp_found;
    logic         exp_led;
    logic [W-1:0] exp_nonce;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int i, input logic [W-1:0] v, input bit expect_push);
    golden_valid[i]          = 1'b1;
    golden_nonce[i*W +: W]   = v;
    if (expect_push) begin
      exp_q.push_back(v);
      exp_found++;
    end
  endtask

  // One clock: score any pop about to happen, advance, then drop pulses.
  task automatic cyc();
    if (tx_valid && tx_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected none", tx_nonce);
      end else begin
        chk("sb_order", tx_nonce, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    golden_valid = '0;
    flush        = 1'b0;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    tx_ready = 1'b0;
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_sb_left", exp_q.size(), 0);
    chk("drain_found", 32'(found_count), exp_found & 255);
    chk("drain_led", 32'(led_found), exp_found & 1);
  endtask

  initial begin
    rst          = 1'b1;
    golden_valid = '0;
    golden_nonce = '0;
    flush        = 1'b0;
    tx_ready     = 1'b0;
    #12;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_nonce", tx_nonce, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_found", 32'(found_count), 0);
    chk("rst_led", 32'(led_found), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single report and a second one, cycle by cycle.
    vecs[0] = '{1'b1, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 0, 32'h0,        1'b0, 1'b1, 1, 1, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 0, 32'h0,        1'b0, 1'b1, 1, 1, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 0, 32'h0,        1'b1, 1'b0, 0, 1, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 0, 32'hCAFE0001, 1'b1, 1'b0, 0, 1, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 0, 32'h0,        1'b1, 1'b1, 1, 2, 1'b0, 32'hCAFE0001};
    vecs[6] = '{1'b0, 0, 32'h0,        1'b1, 1'b0, 0, 2, 1'b0, 32'h0};
    for (int v = 0; v < 7; v++) begin
      tx_ready = vecs[v].ready;
      if (vecs[v].pv) pulse(vecs[v].idx, vecs[v].nonce, 1'b1);
      cyc();
      chk("tbl_valid", 32'(tx_valid), 32'(vecs[v].exp_valid));
      chk("tbl_count", 32'(fifo_count), vecs[v].exp_count);
      chk("tbl_found", 32'(found_count), vecs[v].exp_found);
      chk("tbl_led", 32'(led_found), 32'(vecs[v].exp_led));
      if (vecs[v].exp_valid) chk("tbl_nonce", tx_nonce, vecs[v].exp_nonce);
    end
    tx_ready = 1'b0;

    // rr is 1; a grant to hasher 2 brings it to 0.
    pulse(2, 32'h22220000, 1'b1);
    cyc();
    drain();

    // Simultaneous reports from rr=0: three consecutive transmissions.
    tx_ready = 1'b1;
    pulse(0, 32'h11111111, 1'b1);
    pulse(1, 32'h22222222, 1'b1);
    pulse(2, 32'h33333333, 1'b1);
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("simul_valid", 32'(tx_valid), 1);
      cyc();
    end
    chk("simul_done", 32'(tx_valid), 0);
    drain();

    // rr back at 0: hasher 0 beats hasher 2.
    pulse(0, 32'h000000A0, 1'b1);
    pulse(2, 32'h000000A2, 1'b1);
    cyc();
    drain();
    // Grant to hasher 1 moves rr to 2.
    pulse(1, 32'h000000A1, 1'b1);
    cyc();
    drain();
    // rr=2: hasher 2 first, then 0; rr becomes 1.
    pulse(2, 32'h000000B2, 1'b1);
    pulse(0, 32'h000000B0, 1'b1);
    cyc();
    drain();
    // rr=1: hasher 1 beats hasher 0.
    pulse(1, 32'h000000C1, 1'b1);
    pulse(0, 32'h000000C0, 1'b1);
    cyc();
    drain();

    // Same-cycle grant and recapture on hasher 1.
    pulse(1, 32'h0000000A, 1'b1);
    cyc();
    pulse(1, 32'h0000000B, 1'b1);
    cyc();
    cyc();
    chk("recap_count", 32'(fifo_count), 2);
    chk("recap_overflow", 32'(overflow), 0);
    drain();

    // Backpressure: FIFO fills with 1..4, slot holds 5, 6 is dropped.
    for (int v = 1; v <= 5; v++) begin
      pulse(0, W'(v), 1'b1);
      cyc();
      cyc();
    end
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_head", tx_nonce, 1);
    chk("bp_no_overflow", 32'(overflow), 0);
    pulse(0, 32'd6, 1'b0);
    cyc();
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_count_held", 32'(fifo_count), 4);
    tx_ready = 1'b1;
    cyc();
    chk("bp_full_pop", 32'(fifo_count), 3);
    drain();

    // Flush with 3 queued, one pending slot and a simultaneous pulse.
    for (int v = 0; v < 3; v++) begin
      pulse(0, 32'h100 + W'(v), 1'b1);
      cyc();
      cyc();
    end
    chk("fl_pre_count", 32'(fifo_count), 3);
    pulse(2, 32'h200, 1'b0);
    cyc();
    flush    = 1'b1;
    tx_ready = 1'b1;
    pulse(1, 32'h300, 1'b0);
    cyc();
    tx_ready = 1'b0;
    exp_q.delete();
    chk("fl_count", 32'(fifo_count), 0);
    chk("fl_valid", 32'(tx_valid), 0);
    chk("fl_found", 32'(found_count), exp_found & 255);
    cyc();
    cyc();
    chk("fl_no_capture", 32'(fifo_count), 0);
    chk("fl_found_hold", 32'(found_count), exp_found & 255);
    chk("fl_overflow_kept", 32'(overflow), 1);

    // Asynchronous reset between edges.
    pulse(0, 32'h55, 1'b1);
    cyc();
    cyc();
    chk("ar_pre_count", 32'(fifo_count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(tx_valid), 0);
    chk("ar_nonce", tx_nonce, 0);
    chk("ar_count", 32'(fifo_count), 0);
    chk("ar_overflow", 32'(overflow), 0);
    chk("ar_found", 32'(found_count), 0);
    chk("ar_led", 32'(led_found), 0);
    exp_q.delete();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_after_count", 32'(fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
